// File: rtl/dmem_pkg.sv
// Shared types and access-decode helpers for the pipelined RV32 data memory.
package dmem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_mask_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    function automatic logic [3:0] byte_en(input logic [2:0] mask, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (mem_mask_e'(mask))
            MEM_B, MEM_BU: be = 4'b0001 << off;
            MEM_H, MEM_HU: be = off[1] ? 4'b1100 : 4'b0011;
            MEM_W:         be = 4'b1111;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

    // Unsigned variants are load-only; an address past the last word never wraps.
    function automatic logic access_fault(input logic [2:0] mask, input logic we,
                                          input logic [31:0] addr, input logic [31:0] depth);
        logic f;
        f = 1'b0;
        case (mem_mask_e'(mask))
            MEM_B:   f = 1'b0;
            MEM_BU:  f = we;
            MEM_H:   f = addr[0];
            MEM_HU:  f = addr[0] | we;
            MEM_W:   f = |addr[1:0];
            default: f = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= depth) begin
            f = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half of a loaded word and extends it per funct3.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  mask,
    input  logic [1:0]  off,
    output logic [31:0] value
);

    logic [7:0]  lane;
    logic [15:0] half;

    always_comb begin
        value = '0;
        lane  = word[8*off +: 8];
        half  = off[1] ? word[31:16] : word[15:0];
        case (mem_mask_e'(mask))
            MEM_B:   value = {{24{lane[7]}}, lane};
            MEM_BU:  value = {24'h000000, lane};
            MEM_H:   value = {{16{half[15]}}, half};
            MEM_HU:  value = {16'h0000, half};
            MEM_W:   value = word;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_pipelined.sv
// Single-port RV32 data memory: init sweep after reset, per-lane byte writes,
// registered reads and an RD_LAT-cycle in-order response pipeline.
module data_mem_pipelined
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned INIT_IDX    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mask,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e   state_reg;
    logic [AW-1:0] sweep_idx_reg;
    logic          ready_reg;
    logic          init_done_reg;

    logic          s1_valid_reg;
    logic          s1_fault_reg;
    logic          s1_zero_reg;
    logic [2:0]    s1_mask_reg;
    logic [1:0]    s1_off_reg;

    logic          accept;
    logic          acc_fault;
    logic          rd_en;
    logic [AW-1:0] word_idx;
    logic [AW-1:0] wr_idx;
    logic [3:0]    store_be;
    logic [3:0]    lane_we;
    logic [31:0]   store_lanes;
    logic [31:0]   sweep_word;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [31:0]   load_val;
    logic [31:0]   s1_data;

    assign accept    = req_valid & ready_reg;
    assign acc_fault = access_fault(req_mask, req_we, req_addr, 32'(DEPTH_WORDS));
    assign word_idx  = req_addr[AW+1:2];
    assign store_be  = byte_en(req_mask, req_addr[1:0]);
    assign rd_en     = accept & ~req_we & ~acc_fault;
    assign sweep_word = (INIT_IDX != 0) ? 32'(sweep_idx_reg) : 32'h0;

    always_comb begin
        store_lanes = req_wdata;
        case (mem_mask_e'(req_mask))
            MEM_B:   store_lanes = {4{req_wdata[7:0]}};
            MEM_H:   store_lanes = {2{req_wdata[15:0]}};
            default: store_lanes = req_wdata;
        endcase
    end

    // The sweep and the request path share the single write port.
    assign wr_idx  = (state_reg == INIT) ? sweep_idx_reg : word_idx;
    assign wr_data = (state_reg == INIT) ? sweep_word : store_lanes;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_q_reg;

            assign lane_we[gi] = (state_reg == INIT) |
                                 (accept & req_we & ~acc_fault & store_be[gi]);

            always_ff @(posedge clk) begin
                if (reset && lane_we[gi]) begin
                    lane_mem[wr_idx] <= wr_data[8*gi +: 8];
                end
                if (reset && rd_en) begin
                    rd_q_reg <= lane_mem[word_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_q_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= INIT;
            sweep_idx_reg <= '0;
            ready_reg     <= 1'b0;
            init_done_reg <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_fault_reg  <= 1'b0;
            s1_zero_reg   <= 1'b1;
        end else begin
            s1_valid_reg <= accept;
            // Stage-1 sideband only moves on accept so the response fields hold between pulses.
            if (accept) begin
                s1_fault_reg <= acc_fault;
                s1_zero_reg  <= acc_fault | req_we;
                s1_mask_reg  <= req_mask;
                s1_off_reg   <= req_addr[1:0];
            end
            if (state_reg == INIT) begin
                sweep_idx_reg <= sweep_idx_reg + AW'(1);
                if (sweep_idx_reg == AW'(DEPTH_WORDS - 1)) begin
                    state_reg     <= RUN;
                    ready_reg     <= 1'b1;
                    init_done_reg <= 1'b1;
                end
            end
        end
    end

    dmem_load_align u_align (
        .word  (rd_word),
        .mask  (s1_mask_reg),
        .off   (s1_off_reg),
        .value (load_val)
    );

    assign s1_data = s1_zero_reg ? 32'h0 : load_val;

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rsp_valid = s1_valid_reg;
            assign rsp_fault = s1_fault_reg;
            assign rsp_rdata = s1_data;
        end else begin : g_lat2
            logic        rsp_valid_reg;
            logic        rsp_fault_reg;
            logic [31:0] rsp_rdata_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    rsp_valid_reg <= 1'b0;
                    rsp_fault_reg <= 1'b0;
                    rsp_rdata_reg <= '0;
                end else begin
                    rsp_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        rsp_fault_reg <= s1_fault_reg;
                        rsp_rdata_reg <= s1_data;
                    end
                end
            end

            assign rsp_valid = rsp_valid_reg;
            assign rsp_fault = rsp_fault_reg;
            assign rsp_rdata = rsp_rdata_reg;
        end
    endgenerate

    assign req_ready = ready_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_data_mem_pipelined.sv
// Drives one request stream into RD_LAT=1 and RD_LAT=2 instances and checks both
// against a word-array reference model and a per-cycle response schedule.
module tb_data_mem_pipelined;

    localparam int DEPTH = 1024;
    localparam logic [2:0] M_B = 3'b000, M_H = 3'b001, M_W = 3'b010, M_BU = 3'b100, M_HU = 3'b101;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mask;

    logic        req_ready_1, rsp_valid_1, rsp_fault_1, init_done_1;
    logic [31:0] rsp_rdata_1;
    logic        req_ready_2, rsp_valid_2, rsp_fault_2, init_done_2;
    logic [31:0] rsp_rdata_2;

    data_mem_pipelined #(.DEPTH_WORDS(DEPTH), .RD_LAT(1), .INIT_IDX(1)) u_lat1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .rsp_fault(rsp_fault_1),
        .init_done(init_done_1)
    );

    data_mem_pipelined #(.DEPTH_WORDS(DEPTH), .RD_LAT(2), .INIT_IDX(1)) u_lat2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2), .rsp_fault(rsp_fault_2),
        .init_done(init_done_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          acc;
        logic        f;
        logic [31:0] d;
    } exp_t;

    int unsigned mem_model [DEPTH];
    exp_t        q[$];
    int          ptr [2];
    logic [31:0] last_d [2];
    logic        last_f [2];
    int          cyc;
    int          s_count;
    int          checks;
    int          errors;

    // Reference semantics: RV32 load/store on a word array, faults leave memory untouched.
    function automatic void ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                       input logic [2:0] mask, output logic f, output logic [31:0] d);
        int unsigned wi, sh, v, w;
        wi = addr / 4;
        sh = 8 * (addr % 4);
        f = 1'b0;
        d = 32'h0;
        if (mask == 3'b011 || mask == 3'b110 || mask == 3'b111) f = 1'b1;
        if (we && (mask == M_BU || mask == M_HU)) f = 1'b1;
        if ((mask == M_H || mask == M_HU) && (addr % 2 != 0)) f = 1'b1;
        if (mask == M_W && (addr % 4 != 0)) f = 1'b1;
        if (wi >= DEPTH) f = 1'b1;
        if (f) return;
        w = mem_model[wi];
        if (we) begin
            if (mask == M_B)      mem_model[wi] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            else if (mask == M_H) mem_model[wi] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            else                  mem_model[wi] = wd;
        end else begin
            if (mask == M_B || mask == M_BU) begin
                v = (w >> sh) & 32'hFF;
                d = (mask == M_B && v >= 128) ? (v | 32'hFFFFFF00) : v;
            end else if (mask == M_H || mask == M_HU) begin
                v = (w >> sh) & 32'hFFFF;
                d = (mask == M_H && v >= 32768) ? (v | 32'hFFFF0000) : v;
            end else begin
                d = w;
            end
        end
    endfunction

    task automatic check_one(input int k, input int lat, input logic rdy, input logic done,
                             input logic v, input logic [31:0] d, input logic f);
        logic exp_v;
        logic exp_rdy;
        exp_rdy = (s_count >= DEPTH);
        exp_v = (ptr[k] < q.size()) && (q[ptr[k]].acc + lat == cyc);
        if (exp_v) begin
            last_d[k] = q[ptr[k]].d;
            last_f[k] = q[ptr[k]].f;
            ptr[k]++;
        end
        checks++;
        assert (rdy === exp_rdy) else begin
            errors++; $error("FAIL req_ready lat%0d cyc %0d got %b exp %b", lat, cyc, rdy, exp_rdy);
        end
        checks++;
        assert (done === exp_rdy) else begin
            errors++; $error("FAIL init_done lat%0d cyc %0d got %b exp %b", lat, cyc, done, exp_rdy);
        end
        checks++;
        assert (v === exp_v) else begin
            errors++; $error("FAIL rsp_valid lat%0d cyc %0d got %b exp %b", lat, cyc, v, exp_v);
        end
        checks++;
        assert (d === last_d[k]) else begin
            errors++; $error("FAIL rsp_rdata lat%0d cyc %0d got %h exp %h", lat, cyc, d, last_d[k]);
        end
        checks++;
        assert (f === last_f[k]) else begin
            errors++; $error("FAIL rsp_fault lat%0d cyc %0d got %b exp %b", lat, cyc, f, last_f[k]);
        end
    endtask

    task automatic step();
        logic        rst_e;
        logic        f;
        logic [31:0] d;
        exp_t        e;
        rst_e = reset;
        if (rst_e && req_valid && s_count >= DEPTH) begin
            ref_access(req_we, req_addr, req_wdata, req_mask, f, d);
            e.acc = cyc;
            e.f   = f;
            e.d   = d;
            q.push_back(e);
            $display("txn cyc=%0d we=%0d addr=%h mask=%0d wdata=%h fault=%0d rdata=%h",
                     cyc, req_we, req_addr, req_mask, req_wdata, f, d);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_e) begin
            q.delete();
            ptr[0] = 0; ptr[1] = 0;
            last_d[0] = '0; last_d[1] = '0;
            last_f[0] = 1'b0; last_f[1] = 1'b0;
            s_count = 0;
            for (int i = 0; i < DEPTH; i++) mem_model[i] = i;
        end else if (s_count < DEPTH) begin
            s_count++;
        end
        check_one(0, 1, req_ready_1, init_done_1, rsp_valid_1, rsp_rdata_1, rsp_fault_1);
        check_one(1, 2, req_ready_2, init_done_2, rsp_valid_2, rsp_rdata_2, rsp_fault_2);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] mask);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_mask  = mask;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] exp_d, input logic exp_f);
        checks++;
        assert (rsp_rdata_1 === exp_d && rsp_fault_1 === exp_f) else begin
            errors++; $error("FAIL %s lat1 got %h/%b exp %h/%b", tag, rsp_rdata_1, rsp_fault_1, exp_d, exp_f);
        end
        checks++;
        assert (rsp_rdata_2 === exp_d && rsp_fault_2 === exp_f) else begin
            errors++; $error("FAIL %s lat2 got %h/%b exp %h/%b", tag, rsp_rdata_2, rsp_fault_2, exp_d, exp_f);
        end
    endtask

    task automatic access_expect(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [2:0] mask,
                                 input logic [31:0] exp_d, input logic exp_f);
        issue(we, addr, wd, mask);
        step();
        idle();
        step();
        step();
        expect_rsp(tag, exp_d, exp_f);
    endtask

    task automatic run_init();
        for (int i = 0; i < DEPTH; i++) begin
            // Requests offered during the sweep must be ignored.
            if ($urandom_range(0, 3) == 0) issue(1'b1, 32'($urandom_range(0, DEPTH - 1)) * 4, $urandom, M_W);
            else idle();
            step();
        end
        idle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; s_count = 0;
        ptr[0] = 0; ptr[1] = 0;
        last_d[0] = '0; last_d[1] = '0; last_f[0] = 1'b0; last_f[1] = 1'b0;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_mask = M_W;

        repeat (3) step();
        reset = 1'b1;
        run_init();

        access_expect("lw_init_0x010", 1'b0, 32'h010, 32'h0, M_W, 32'h00000004, 1'b0);

        access_expect("sb_0x101", 1'b1, 32'h101, 32'h000000AB, M_B, 32'h0, 1'b0);
        access_expect("lw_0x100", 1'b0, 32'h100, 32'h0, M_W, 32'h0000AB40, 1'b0);
        access_expect("lb_0x101", 1'b0, 32'h101, 32'h0, M_B, 32'hFFFFFFAB, 1'b0);
        access_expect("lbu_0x101", 1'b0, 32'h101, 32'h0, M_BU, 32'h000000AB, 1'b0);

        access_expect("sh_0x202", 1'b1, 32'h202, 32'h00008001, M_H, 32'h0, 1'b0);
        access_expect("lh_0x202", 1'b0, 32'h202, 32'h0, M_H, 32'hFFFF8001, 1'b0);
        access_expect("lhu_0x202", 1'b0, 32'h202, 32'h0, M_HU, 32'h00008001, 1'b0);
        access_expect("lw_0x200", 1'b0, 32'h200, 32'h0, M_W, 32'h80010080, 1'b0);

        access_expect("lw_misaligned", 1'b0, 32'h103, 32'h0, M_W, 32'h0, 1'b1);
        access_expect("sw_out_of_range", 1'b1, 32'h1000, 32'h12345678, M_W, 32'h0, 1'b1);
        access_expect("lw_last_word", 1'b0, 32'hFFC, 32'h0, M_W, 32'h000003FF, 1'b0);
        access_expect("store_mask_bu", 1'b1, 32'h300, 32'h55, M_BU, 32'h0, 1'b1);
        access_expect("lh_odd", 1'b0, 32'h301, 32'h0, M_H, 32'h0, 1'b1);
        access_expect("illegal_mask", 1'b0, 32'h300, 32'h0, 3'b111, 32'h0, 1'b1);

        // Store then load on consecutive cycles with no bubble.
        issue(1'b1, 32'h040, 32'hDEADBEEF, M_W);
        step();
        issue(1'b0, 32'h040, 32'h0, M_W);
        step();
        idle();
        step();
        step();
        expect_rsp("sw_lw_back_to_back", 32'hDEADBEEF, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                int unsigned wi;
                wi = ($urandom_range(0, 7) == 0) ? $urandom_range(1016, 1100) : $urandom_range(0, DEPTH - 1);
                issue($urandom_range(0, 1) == 1, wi * 4 + $urandom_range(0, 3), $urandom,
                      3'($urandom_range(0, 7)));
            end else begin
                idle();
            end
            step();
        end
        idle();
        repeat (3) step();

        // Reset while a load is in flight: no late response, contents re-swept.
        issue(1'b0, 32'h040, 32'h0, M_W);
        step();
        reset = 1'b0;
        idle();
        step();
        step();
        reset = 1'b1;
        run_init();
        access_expect("lw_after_reinit", 1'b0, 32'h040, 32'h0, M_W, 32'h00000010, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
